// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB byte buffers (tx and rx sides).
package usb_buf_pkg;

    // Default byte width of the buffer storage.
    localparam int USB_BUF_DATA_W = 8;

    // Pointer/occupancy width: address bits plus one wrap bit, so that a
    // completely full buffer (DEPTH bytes) is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usb_buf_ram.sv
// Byte storage for the USB buffers: one synchronous write port, one
// asynchronous read port, no reset (contents are don't-care until written).
module usb_buf_ram #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the addressed byte on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read so the head byte falls through without a cycle delay.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/usb_tx_retry_buffer.sv
// Transmit byte buffer with packet-level retry: the read pointer can be
// checkpointed (mark), rewound to the checkpoint (NAK/timeout) and committed
// (ACK). Storage is only released on commit, so a failed packet replays
// without the host writing it again.
module usb_tx_retry_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int DATA_W   = USB_BUF_DATA_W,
    parameter int AF_LEVEL = DEPTH - 8,
    localparam int OCC_W   = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              get_tx_packet_data,
    output logic [DATA_W-1:0] tx_packet_data,
    input  logic              tx_mark,
    input  logic              tx_rewind,
    input  logic              tx_commit,
    input  logic              flush,
    output logic [OCC_W-1:0]  buffer_occupancy,
    output logic [OCC_W-1:0]  tx_available,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int               AW       = OCC_W - 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] AF_C     = OCC_W'(AF_LEVEL);

    // Pointers carry a wrap bit; ordering is free <= mark <= rd <= wr (mod 2*DEPTH).
    logic [OCC_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [OCC_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [OCC_W-1:0] mark_ptr_q, mark_ptr_d;
    logic [OCC_W-1:0] free_ptr_q, free_ptr_d;
    logic             overflow_err_q,  overflow_err_d;
    logic             underflow_err_q, underflow_err_d;

    logic              store_ok;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // Status flags, derived only from registered pointers.
    always_comb begin
        buffer_occupancy = wr_ptr_q - free_ptr_q;
        tx_available     = wr_ptr_q - rd_ptr_q;
        empty            = (tx_available == '0);
        full             = (buffer_occupancy == DEPTH_C);
        almost_full      = (buffer_occupancy >= AF_C);
        overflow_err     = overflow_err_q;
        underflow_err    = underflow_err_q;
        tx_packet_data   = empty ? '0 : ram_rdata;
    end

    // Store path: a store while full is dropped even if a commit frees
    // space in the same cycle, since full is taken from registered state.
    always_comb begin
        store_ok = store_tx_data && !full;
        ram_we   = store_ok && !flush;
    end

    // Next-state pointer and error logic with flush > rewind > get/mark/commit.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        mark_ptr_d      = mark_ptr_q;
        free_ptr_d      = free_ptr_q;
        overflow_err_d  = overflow_err_q;
        underflow_err_d = underflow_err_q;

        if (flush) begin
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            mark_ptr_d      = '0;
            free_ptr_d      = '0;
            overflow_err_d  = 1'b0;
            underflow_err_d = 1'b0;
        end else begin
            if (store_ok) begin
                wr_ptr_d = wr_ptr_q + OCC_W'(1);
            end else if (store_tx_data) begin
                overflow_err_d = 1'b1;
            end

            if (tx_rewind) begin
                // A get in the same cycle is swallowed silently by the replay.
                rd_ptr_d = mark_ptr_q;
            end else begin
                // Mark and commit both capture the pre-increment read pointer.
                if (tx_mark || tx_commit) begin
                    mark_ptr_d = rd_ptr_q;
                end
                if (tx_commit) begin
                    free_ptr_d = rd_ptr_q;
                end
                if (get_tx_packet_data) begin
                    if (!empty) begin
                        rd_ptr_d = rd_ptr_q + OCC_W'(1);
                    end else begin
                        underflow_err_d = 1'b1;
                    end
                end
            end
        end
    end

    // Register pointers and sticky errors; reset discards any packet state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            mark_ptr_q      <= '0;
            free_ptr_q      <= '0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            mark_ptr_q      <= mark_ptr_d;
            free_ptr_q      <= free_ptr_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    usb_buf_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (tx_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/usb_tx_retry_buffer.md
# usb_tx_retry_buffer

Parametrised transmit-side byte buffer between the host-side writer and `usb_tx`. It supersedes the fixed 64-byte TX path of the current data buffer and adds packet-level retransmission. The read pointer can be checkpointed at packet start, rewound on NAK/timeout, and committed on ACK. Storage is released only on commit, so a failed packet replays without host involvement.

## Interface
Parameters:
- `DEPTH`, 64, byte capacity; power of two, ≥ 4
- `DATA_W`, 8, byte width
- `AF_LEVEL`, DEPTH-8, `almost_full` threshold on `buffer_occupancy`
- derived `OCC_W` = $clog2(DEPTH)+1

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `store_tx_data`  in  1  write `tx_data` this cycle
- `tx_data`  in  DATA_W  write byte
- `get_tx_packet_data`  in  1  consume current `tx_packet_data`
- `tx_packet_data`  out  DATA_W  first-word-fall-through head byte
- `tx_mark`  in  1  checkpoint read pointer (packet start)
- `tx_rewind`  in  1  restore read pointer to checkpoint (retry)
- `tx_commit`  in  1  release bytes before the read pointer (ACK)
- `flush`  in  1  discard all contents, clear errors
- `buffer_occupancy`  out  OCC_W  bytes held: written minus released
- `tx_available`  out  OCC_W  bytes not yet read: written minus read
- `empty`  out  1  `tx_available` == 0
- `full`  out  1  `buffer_occupancy` == DEPTH
- `almost_full`  out  1  `buffer_occupancy` ≥ AF_LEVEL
- `overflow_err`  out  1  sticky; store attempted while full
- `underflow_err`  out  1  sticky; get attempted while empty

## Operation
- Four OCC_W-bit pointers with wrap bit: `wr_ptr`, `rd_ptr`, `mark_ptr`, `free_ptr`. RAM is indexed by the low $clog2(DEPTH) bits. Invariant: `free_ptr` ≤ `mark_ptr` ≤ `rd_ptr` ≤ `wr_ptr`, all modulo 2·DEPTH.
- Store: if `!full`, write RAM[wr_ptr] and increment `wr_ptr`. If full, drop the byte and set `overflow_err`.
- Get: if `!empty`, increment `rd_ptr`. If empty, hold `rd_ptr` and set `underflow_err`.
- Mark: `mark_ptr` ← `rd_ptr`, using the pre-increment value if get is in the same cycle.
- Commit: `free_ptr` ← `rd_ptr` and `mark_ptr` ← `rd_ptr`, both pre-increment.
- Rewind: `rd_ptr` ← `mark_ptr`. A get in the same cycle is ignored and raises no error.
- Priority when asserted in the same cycle:
  - `flush` overrides everything.
  - `tx_rewind` suppresses get, mark, and commit.
  - Otherwise get, mark, and commit combine as above.
  - Store is independent of all of these except flush.
- Flush: all pointers ← 0, both errors ← 0, RAM contents don't-care.
- `tx_packet_data` = RAM[rd_ptr] when `!empty`, else all-zeros.
- Arithmetic: occupancy = `wr_ptr` − `free_ptr` and available = `wr_ptr` − `rd_ptr`, both as OCC_W-bit modular subtraction. Wrap-around is handled by the extra bit, and DEPTH itself is representable.
- `full` is evaluated from registered state only. A store coinciding with a commit that frees space is still dropped when `full` is asserted.

## Timing
- Reset values:
  - `buffer_occupancy` 0, `tx_available` 0
  - `empty` 1, `full` 0, `almost_full` (AF_LEVEL==0)
  - `overflow_err` 0, `underflow_err` 0
  - `tx_packet_data` 0
  - all pointers 0
- Reset and flush take effect at the clock edge where they are sampled. Reset mid-packet discards the mark/commit state.
- Pointer updates occur at the edge where their control is sampled. All status outputs are combinational from registered pointers, so they reflect an event one cycle after it is sampled.
- Store-to-read latency is 1 cycle. A byte stored into an empty buffer appears on `tx_packet_data` the next cycle. There is no write-through.
- Get: `tx_packet_data` is valid in the same cycle as `get_tx_packet_data`. The next byte is presented the following cycle.
- Rewind: the byte at the mark is on `tx_packet_data` the cycle after `tx_rewind`.
- Errors assert the cycle after the offending request and hold until `flush` or `rst`.

## Structure
- Package `usb_buf_pkg`: `DATA_W` default and the `OCC_W` derivation function. Shared with the rx side.
- Sub-module `usb_buf_ram`: one write port and one asynchronous read port, DEPTH × DATA_W, no reset.
- Top-level RTL owns the pointers, priority logic, flags, and errors.
- Single clock domain; no internal state machine beyond the pointer registers.

## Test plan
- **Basic write/read:** reset, store 0x11..0x1A (10 bytes), then 10 gets. Reads return 0x11..0x1A in order. After the gets, `tx_available` = 0 and `empty` = 1, while `buffer_occupancy` stays 10 until `tx_commit`, then 0.
- **Retry after partial read:** store 8 bytes, `tx_mark`, 5 gets, `tx_rewind`. The next reads restart at byte 0, and `tx_available` = 8. Then do 8 gets and `tx_commit`: `buffer_occupancy` = 0.
- **Full and overflow (DEPTH=64):**
  - Store 64 bytes: `full` = 1, `almost_full` = 1 from occupancy 56.
  - 65th store: dropped, `overflow_err` = 1, occupancy stays 64.
  - 1 get plus commit: `full` = 0.
- **Empty read:** get while empty. `underflow_err` = 1, `tx_packet_data` = 0x00, pointers unchanged. A subsequent `flush` clears the error.
- **Simultaneous events:**
  - get + rewind in the same cycle: no advance, no error.
  - get + commit in the same cycle: occupancy drops by the pre-increment count.
  - store + flush in the same cycle: buffer empty afterwards.
- **Wrap-around and reset mid-packet:** run 3×DEPTH bytes through with commits after every 16 bytes. The data matches the stored sequence and occupancy never exceeds 16. Asserting `rst` mid-packet restores all reset values the next cycle.
